// File: rtl/match_pkg.sv
// Shared state type and default sizing for the match event monitor.
package match_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        ALARM = 2'b10
    } mon_state_t;

    localparam int unsigned MON_CNT_W   = 8;
    localparam int unsigned MON_WIN_LEN = 16;
    localparam int unsigned MON_THRESH  = 3;

endpackage

// File: rtl/rise_detect.sv
// Registers a level input and flags its rising edge combinationally.
module rise_detect (
    input  logic Clock,
    input  logic Reset,
    input  logic d,
    output logic rise
);

    logic z_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            z_q <= 1'b0;
        end else begin
            z_q <= d;
        end
    end

    assign rise = d & ~z_q;

endmodule

// File: rtl/match_event_monitor.sv
// Counts rising edges of the match flag and raises a latched alarm on THRESH events in a window.
// Optional MATCH_ALARM_AUTOCLEAR_EN: ALARM also self-clears after WIN_LEN cycles without Ack.
module match_event_monitor
    import match_pkg::*;
#(
    parameter int unsigned CNT_W   = MON_CNT_W,
    parameter int unsigned WIN_LEN = MON_WIN_LEN,
    parameter int unsigned THRESH  = MON_THRESH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             z,
    input  logic             En,
    input  logic             Ack,
    output logic [CNT_W-1:0] Count,
    output logic             Alarm,
    output logic             Busy
);

    localparam int unsigned WIN_W  = $clog2(WIN_LEN);
    localparam int unsigned HITS_W = $clog2(THRESH + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    // Opening event is cycle 0, so the counter covers cycles 1..WIN_LEN-1 and hits 0 on the last.
    localparam logic [WIN_W-1:0]  WIN_OPEN  = WIN_W'(WIN_LEN - 2);
    localparam logic [HITS_W-1:0] HITS_TRIP = HITS_W'(THRESH - 1);
`ifdef MATCH_ALARM_AUTOCLEAR_EN
    localparam logic [WIN_W-1:0]  WIN_ALARM = WIN_W'(WIN_LEN - 1);
`endif

    logic              rise;
    mon_state_t        state;
    logic [WIN_W-1:0]  win;
    logic [HITS_W-1:0] hits;

    rise_detect u_rise_detect (
        .Clock (Clock),
        .Reset (Reset),
        .d     (z),
        .rise  (rise)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Count <= '0;
        end else if (rise && (Count != CNT_MAX)) begin
            Count <= Count + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            win   <= '0;
            hits  <= '0;
            Alarm <= 1'b0;
            Busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise && En) begin
                        hits <= HITS_W'(1);
                        win  <= WIN_OPEN;
                        if (THRESH == 1) begin
                            state <= ALARM;
                            Alarm <= 1'b1;
                            Busy  <= 1'b0;
`ifdef MATCH_ALARM_AUTOCLEAR_EN
                            win   <= WIN_ALARM;
`endif
                        end else begin
                            state <= RUN;
                            Alarm <= 1'b0;
                            Busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!En) begin
                        state <= IDLE;
                        hits  <= '0;
                        Busy  <= 1'b0;
                    end else if (rise && (hits == HITS_TRIP)) begin
                        // Threshold wins over expiry on the window's last cycle.
                        state <= ALARM;
                        Alarm <= 1'b1;
                        Busy  <= 1'b0;
`ifdef MATCH_ALARM_AUTOCLEAR_EN
                        win   <= WIN_ALARM;
`endif
                    end else if (win == '0) begin
                        state <= IDLE;
                        hits  <= '0;
                        Busy  <= 1'b0;
                    end else begin
                        win  <= win - 1'b1;
                        hits <= hits + HITS_W'(rise);
                    end
                end
                ALARM: begin
                    if (Ack) begin
                        state <= IDLE;
                        hits  <= '0;
                        Alarm <= 1'b0;
                    end
`ifdef MATCH_ALARM_AUTOCLEAR_EN
                    else if (win == '0) begin
                        state <= IDLE;
                        hits  <= '0;
                        Alarm <= 1'b0;
                    end else begin
                        win <= win - 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    hits  <= '0;
                    Alarm <= 1'b0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_event_monitor.sv
// Self-checking bench: directed scenarios plus random traffic against a timestamp-based model.
module tb_match_event_monitor;

    localparam int CNT_W   = 8;
    localparam int WIN_LEN = 16;
    localparam int THRESH  = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_ALARM = 2;

    logic             Clock;
    logic             Reset;
    logic             z;
    logic             En;
    logic             Ack;
    logic [CNT_W-1:0] Count;
    logic             Alarm;
    logic             Busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: absolute edge index, window start time and events seen in it.
    int t = 0;
    int m_count = 0;
    int m_mode = M_IDLE;
    int m_start = 0;
    int m_alarm_start = 0;
    int m_events = 0;
    bit m_prev_z = 1'b0;

    match_event_monitor #(
        .CNT_W   (CNT_W),
        .WIN_LEN (WIN_LEN),
        .THRESH  (THRESH)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .z     (z),
        .En    (En),
        .Ack   (Ack),
        .Count (Count),
        .Alarm (Alarm),
        .Busy  (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic void model_edge(input bit zi, input bit ei, input bit ai, input bit ri);
        bit r;
        t++;
        if (ri) begin
            m_count  = 0;
            m_mode   = M_IDLE;
            m_events = 0;
            m_prev_z = 1'b0;
            return;
        end
        r = zi && !m_prev_z;
        m_prev_z = zi;
        if (r && m_count < (1 << CNT_W) - 1) m_count++;
        case (m_mode)
            M_IDLE: begin
                if (r && ei) begin
                    m_start  = t;
                    m_events = 1;
                    if (THRESH == 1) begin
                        m_mode = M_ALARM;
                        m_alarm_start = t;
                    end else begin
                        m_mode = M_RUN;
                    end
                end
            end
            M_RUN: begin
                if (!ei) begin
                    m_mode = M_IDLE;
                end else if (r && m_events + 1 >= THRESH) begin
                    m_mode = M_ALARM;
                    m_alarm_start = t;
                end else if (t - m_start >= WIN_LEN - 1) begin
                    m_mode = M_IDLE;
                end else begin
                    m_events += int'(r);
                end
            end
            default: begin
                if (ai) m_mode = M_IDLE;
`ifdef MATCH_ALARM_AUTOCLEAR_EN
                else if (t - m_alarm_start >= WIN_LEN) m_mode = M_IDLE;
`endif
            end
        endcase
    endfunction

    function automatic logic [CNT_W+1:0] model_out();
        return {CNT_W'(m_count), m_mode == M_RUN, m_mode == M_ALARM};
    endfunction

    // Drive inputs, advance one edge, update the model, then settle past the edge.
    task automatic step(input bit zi, input bit ei, input bit ai, input bit ri);
        z = zi;
        En = ei;
        Ack = ai;
        Reset = ri;
        @(posedge Clock);
        model_edge(zi, ei, ai, ri);
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);
        n_cmp++;
        if ({Count, Busy, Alarm} !== {CNT_W'(0), 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_hold: Count=%0d Busy=%b Alarm=%b, expected 0/0/0", Count, Busy, Alarm);
        end
        step(1, 1, 0, 0);
        n_cmp++;
        if (Count !== CNT_W'(1) || Busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release: Count=%0d Busy=%b, expected Count=1 Busy=1", Count, Busy);
        end
        for (int c = 0; c < 4; c++) begin
            step(0, 1, 0, 0);
            n_cmp++;
            if ({Count, Busy, Alarm} !== model_out()) begin
                n_bad++;
                $display("FAIL reset_after t=%0d: got %b expected %b", t, {Count, Busy, Alarm}, model_out());
            end
        end
    endtask

    task automatic test_threshold();
        step(0, 1, 0, 1);
        for (int c = 0; c < 14; c++) begin
            step(c == 0 || c == 4 || c == 8, 1, c == 12, 0);
            n_cmp++;
            if ({Count, Busy, Alarm} !== model_out()) begin
                n_bad++;
                $display("FAIL threshold c=%0d: got %b expected %b", c, {Count, Busy, Alarm}, model_out());
            end
            if (c == 0) begin
                n_cmp++;
                if (Busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL threshold_busy: Busy=%b expected 1", Busy);
                end
            end
            if (c == 8) begin
                n_cmp++;
                if (Alarm !== 1'b1 || Count !== CNT_W'(3)) begin
                    n_bad++;
                    $display("FAIL threshold_alarm: Alarm=%b Count=%0d, expected 1 and 3", Alarm, Count);
                end
            end
            if (c == 12) begin
                n_cmp++;
                if (Alarm !== 1'b0) begin
                    n_bad++;
                    $display("FAIL threshold_ack: Alarm=%b expected 0", Alarm);
                end
            end
        end
    endtask

    task automatic test_expiry();
        step(0, 1, 0, 1);
        for (int c = 0; c < 24; c++) begin
            step(c == 0 || c == 20, 1, 0, 0);
            n_cmp++;
            if ({Count, Busy, Alarm} !== model_out()) begin
                n_bad++;
                $display("FAIL expiry c=%0d: got %b expected %b", c, {Count, Busy, Alarm}, model_out());
            end
            if (c == 14 || c == 15 || c == 20) begin
                n_cmp++;
                if (Busy !== (c != 15)) begin
                    n_bad++;
                    $display("FAIL expiry_busy c=%0d: Busy=%b expected %b", c, Busy, c != 15);
                end
            end
        end
        n_cmp++;
        if (Alarm !== 1'b0 || Count !== CNT_W'(2)) begin
            n_bad++;
            $display("FAIL expiry_end: Alarm=%b Count=%0d, expected 0 and 2", Alarm, Count);
        end
    endtask

    task automatic test_boundary();
        for (int last = 15; last <= 16; last++) begin
            step(0, 1, 0, 1);
            for (int c = 0; c <= last + 1; c++) begin
                step(c == 0 || c == 5 || c == last, 1, 0, 0);
                n_cmp++;
                if ({Count, Busy, Alarm} !== model_out()) begin
                    n_bad++;
                    $display("FAIL boundary last=%0d c=%0d: got %b expected %b", last, c,
                             {Count, Busy, Alarm}, model_out());
                end
            end
            n_cmp++;
            if (Alarm !== (last == 15) || Busy !== (last == 16)) begin
                n_bad++;
                $display("FAIL boundary_end last=%0d: Alarm=%b Busy=%b, expected %b %b", last, Alarm,
                         Busy, last == 15, last == 16);
            end
        end
    endtask

    task automatic test_saturate();
        step(0, 0, 0, 1);
        for (int c = 0; c < 10; c++) step(1, 0, 0, 0);
        n_cmp++;
        if (Count !== CNT_W'(1)) begin
            n_bad++;
            $display("FAIL saturate_level: Count=%0d expected 1", Count);
        end
        step(0, 0, 0, 0);
        for (int c = 0; c < 600; c++) begin
            step(c % 2 == 0, 0, 0, 0);
            n_cmp++;
            if ({Count, Busy, Alarm} !== model_out()) begin
                n_bad++;
                $display("FAIL saturate c=%0d: got %b expected %b", c, {Count, Busy, Alarm}, model_out());
            end
        end
        n_cmp++;
        if (Count !== CNT_W'(255) || Busy !== 1'b0 || Alarm !== 1'b0) begin
            n_bad++;
            $display("FAIL saturate_end: Count=%0d Busy=%b Alarm=%b, expected 255/0/0", Count, Busy, Alarm);
        end
    endtask

    task automatic test_reset_in_alarm();
        step(0, 1, 0, 1);
        for (int c = 0; c < 6; c++) step(c == 0 || c == 2 || c == 4, 1, 0, 0);
        n_cmp++;
        if (Alarm !== 1'b1) begin
            n_bad++;
            $display("FAIL alarm_enter: Alarm=%b expected 1", Alarm);
        end
        step(1, 1, 0, 1);
        n_cmp++;
        if ({Count, Busy, Alarm} !== {CNT_W'(0), 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL alarm_reset: Count=%0d Busy=%b Alarm=%b, expected 0/0/0", Count, Busy, Alarm);
        end
`ifdef MATCH_ALARM_AUTOCLEAR_EN
        step(0, 1, 0, 1);
        for (int c = 0; c <= 4; c++) step(c == 0 || c == 2 || c == 4, 1, 0, 0);
        for (int c = 1; c <= WIN_LEN; c++) begin
            step(0, 1, 0, 0);
            n_cmp++;
            if (Alarm !== (c < WIN_LEN)) begin
                n_bad++;
                $display("FAIL autoclear c=%0d: Alarm=%b expected %b", c, Alarm, c < WIN_LEN);
            end
        end
`endif
    endtask

    task automatic test_random();
        step(0, 1, 0, 1);
        for (int c = 0; c < 4000; c++) begin
            step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 92,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 199) == 0);
            n_cmp++;
            if ({Count, Busy, Alarm} !== model_out()) begin
                n_bad++;
                $display("FAIL random t=%0d: got %b expected %b", t, {Count, Busy, Alarm}, model_out());
            end
        end
    endtask

    initial begin
        z = 1'b0;
        En = 1'b0;
        Ack = 1'b0;
        Reset = 1'b1;
        test_reset();
        test_threshold();
        test_expiry();
        test_boundary();
        test_saturate();
        test_reset_in_alarm();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
